plc_timer_bank: RTL and testbench

Multi-channel PLC timer bank for the lathe retrofit controller, and the successor to the single-channel AUTO/MAN delay block. It provides NUM_CH independent timer channels. Each channel is individually configured as disabled, manual, on-delay (TON) or off-delay (TOF), with a runtime-programmable preset counted in prescaled ticks. The block adds a shared prescaler, a latched emergency stop with restart interlock, and an elapsed-time readback port. It sits between operator/panel inputs and the spindle, coolant and feed actuator drivers.

---
 rtl/plc_timer_bank_if.sv | 22 ++
 rtl/plc_timer_bank.sv | 156 +++++++++++++++
 tb/tb_plc_timer_bank.sv | 445 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/plc_timer_bank_if.sv
// Configuration and readback bus for plc_timer_bank.
// Ports: cfg_we/cfg_ch/cfg_preset preset write, sel_ch readback select, elapsed readback.
interface plc_timer_bank_if #(
  parameter int CH_W  = 2,
  parameter int CNT_W = 16
);
  logic             cfg_we;
  logic [CH_W-1:0]  cfg_ch;
  logic [CNT_W-1:0] cfg_preset;
  logic [CH_W-1:0]  sel_ch;
  logic [CNT_W-1:0] elapsed;

  modport master (
    output cfg_we, cfg_ch, cfg_preset, sel_ch,
    input  elapsed
  );

  modport slave (
    input  cfg_we, cfg_ch, cfg_preset, sel_ch,
    output elapsed
  );
endinterface

// File: rtl/plc_timer_bank.sv
// Multi-channel PLC timer bank: DIS/MAN/TON/TOF per channel, shared prescaler,
// latched estop with restart interlock, elapsed readback.
// Ports: clk, reset (async, high), estop, start, mode, cfg (slave bus), control, done, fault.
// Optional RETENTIVE_EN: adds clr port, makes TON retentive.
module plc_timer_bank #(
  parameter int NUM_CH     = 4,
  parameter int CNT_W      = 16,
  parameter int PRESCALE   = 50000,
  parameter int DEF_PRESET = 3000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                estop,
  input  logic [NUM_CH-1:0]   start,
  input  logic [2*NUM_CH-1:0] mode,
`ifdef RETENTIVE_EN
  input  logic [NUM_CH-1:0]   clr,
`endif
  plc_timer_bank_if.slave     cfg,
  output logic [NUM_CH-1:0]   control,
  output logic [NUM_CH-1:0]   done,
  output logic                fault
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CNT_W-1:0] ACC_MAX = '1;

  typedef enum logic [1:0] {
    M_DIS = 2'b00,
    M_MAN = 2'b01,
    M_TON = 2'b10,
    M_TOF = 2'b11
  } mode_e;

  logic [PW-1:0]         pcnt;
  logic                  tick;
  logic [CNT_W-1:0]      preset_q [NUM_CH];
  logic [CNT_W-1:0]      acc_q    [NUM_CH];
  logic [CNT_W-1:0]      acc_d    [NUM_CH];
  logic [NUM_CH-1:0]     ctl_d;
  logic [NUM_CH-1:0]     done_d;
  logic [2*NUM_CH-1:0]   mode_q;
  logic                  fault_d;
  logic                  kill;
  logic [CNT_W-1:0]      elapsed_d;

  assign tick    = (pcnt == PW'(PRESCALE - 1));
  // Forced-off covers both the setting edge and the whole latched period.
  assign kill    = estop | fault;
  // Latch releases only once estop is gone and no channel requests a run.
  assign fault_d = estop | (fault & (|start));

  always_comb begin
    logic [CNT_W-1:0] inc;
    mode_e            m;
    logic             st;
    ctl_d  = control;
    done_d = done;
    acc_d  = acc_q;
    inc    = '0;
    m      = M_DIS;
    st     = 1'b0;
    for (int c = 0; c < NUM_CH; c++) begin
      m   = mode_e'(mode[2*c +: 2]);
      st  = start[c];
      inc = (tick && acc_q[c] != ACC_MAX)
          ? acc_q[c] + CNT_W'(1) : acc_q[c];
      if (kill || mode[2*c +: 2] != mode_q[2*c +: 2]) begin
        ctl_d[c]  = 1'b0;
        done_d[c] = 1'b0;
        acc_d[c]  = '0;
      end else begin
        unique case (1'b1)
          (m == M_DIS): begin
            ctl_d[c]  = 1'b0;
            done_d[c] = 1'b0;
            acc_d[c]  = '0;
          end
          (m == M_MAN): begin
            ctl_d[c]  = st;
            done_d[c] = st;
            acc_d[c]  = '0;
          end
          (m == M_TON): begin
            if (st) begin
              acc_d[c] = inc;
              if (done[c] || inc >= preset_q[c]) begin
                ctl_d[c]  = 1'b1;
                done_d[c] = 1'b1;
              end
            end else begin
              ctl_d[c] = 1'b0;
`ifndef RETENTIVE_EN
              done_d[c] = 1'b0;
              acc_d[c]  = '0;
`endif
            end
          end
          (m == M_TOF): begin
            if (st) begin
              ctl_d[c]  = 1'b1;
              done_d[c] = 1'b0;
              acc_d[c]  = '0;
            end else if (control[c]) begin
              acc_d[c] = inc;
              if (inc >= preset_q[c]) begin
                ctl_d[c]  = 1'b0;
                done_d[c] = 1'b1;
              end
            end
          end
          default: ;
        endcase
`ifdef RETENTIVE_EN
        if (clr[c]) begin
          acc_d[c]  = '0;
          done_d[c] = 1'b0;
        end
`endif
      end
    end
  end

  always_comb begin
    elapsed_d = '0;
    if (int'(cfg.sel_ch) < NUM_CH) elapsed_d = acc_q[cfg.sel_ch];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pcnt        <= '0;
      control     <= '0;
      done        <= '0;
      fault       <= 1'b0;
      mode_q      <= '0;
      cfg.elapsed <= '0;
      for (int c = 0; c < NUM_CH; c++) begin
        acc_q[c]    <= '0;
        preset_q[c] <= CNT_W'(DEF_PRESET);
      end
    end else begin
      pcnt        <= tick ? '0 : pcnt + PW'(1);
      control     <= ctl_d;
      done        <= done_d;
      fault       <= fault_d;
      mode_q      <= mode;
      cfg.elapsed <= elapsed_d;
      for (int c = 0; c < NUM_CH; c++) begin
        acc_q[c] <= acc_d[c];
        if (cfg.cfg_we && int'(cfg.cfg_ch) == c)
          preset_q[c] <= cfg.cfg_preset;
      end
    end
  end

endmodule

// File: tb/tb_plc_timer_bank.sv
// Self-checking bench for plc_timer_bank (NUM_CH=4, PRESCALE=1).
// Directed scenarios plus randomized traffic against a behavioural model.
module tb_plc_timer_bank;
  localparam int N = 4;
  localparam int W = 16;
  localparam int MAXV = 65535;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         estop = 1'b0;
  logic [N-1:0] start = '0;
  logic [2*N-1:0] mode = '0;
`ifdef RETENTIVE_EN
  logic [N-1:0] clr = '0;
`endif
  logic [N-1:0] control;
  logic [N-1:0] done;
  logic         fault;

  plc_timer_bank_if #(.CH_W(2), .CNT_W(W)) bus();

  plc_timer_bank #(
    .NUM_CH(N), .CNT_W(W), .PRESCALE(1), .DEF_PRESET(3000)
  ) dut (
    .clk(clk),
    .reset(reset),
    .estop(estop),
    .start(start),
    .mode(mode),
`ifdef RETENTIVE_EN
    .clr(clr),
`endif
    .cfg(bus.slave),
    .control(control),
    .done(done),
    .fault(fault)
  );

  always #5 clk = ~clk;

  int nchk = 0;
  int nerr = 0;

  int           m_acc [N];
  int           m_pre [N];
  int           m_mq  [N];
  logic [N-1:0] m_ctl;
  logic [N-1:0] m_done;
  logic         m_fault;
  logic [W-1:0] m_el;

  task automatic model_reset();
    for (int c = 0; c < N; c++) begin
      m_acc[c] = 0;
      m_pre[c] = 3000;
      m_mq[c]  = 0;
    end
    m_ctl = '0;
    m_done = '0;
    m_fault = 1'b0;
    m_el = '0;
  endtask

  // Timer rules with PRESCALE=1: every clock edge is a tick.
  task automatic model_step();
    logic nf;
    int   md;
    int   nxt;
    logic st;
    nf = estop | (m_fault & (|start));
    m_el = W'(m_acc[bus.sel_ch]);
    for (int c = 0; c < N; c++) begin
      md  = int'(mode[2*c +: 2]);
      st  = start[c];
      nxt = (m_acc[c] >= MAXV) ? MAXV : m_acc[c] + 1;
      if (estop || m_fault || md != m_mq[c]) begin
        m_ctl[c] = 0; m_done[c] = 0; m_acc[c] = 0;
      end else begin
        case (md)
          0: begin m_ctl[c] = 0; m_done[c] = 0; m_acc[c] = 0; end
          1: begin m_ctl[c] = st; m_done[c] = st; m_acc[c] = 0; end
          2: begin
            if (st) begin
              m_acc[c] = nxt;
              if (m_done[c] || nxt >= m_pre[c]) begin
                m_ctl[c] = 1; m_done[c] = 1;
              end
            end else begin
              m_ctl[c] = 0;
`ifndef RETENTIVE_EN
              m_done[c] = 0; m_acc[c] = 0;
`endif
            end
          end
          default: begin
            if (st) begin
              m_ctl[c] = 1; m_done[c] = 0; m_acc[c] = 0;
            end else if (m_ctl[c]) begin
              m_acc[c] = nxt;
              if (nxt >= m_pre[c]) begin
                m_ctl[c] = 0; m_done[c] = 1;
              end
            end
          end
        endcase
`ifdef RETENTIVE_EN
        if (clr[c]) begin m_acc[c] = 0; m_done[c] = 0; end
`endif
      end
      m_mq[c] = md;
    end
    if (bus.cfg_we) m_pre[bus.cfg_ch] = int'(bus.cfg_preset);
    m_fault = nf;
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    estop = 0; start = '0; mode = '0; bus.cfg_we = 0;
`ifdef RETENTIVE_EN
    clr = '0;
`endif
    step();
  endtask

  task automatic cfg_write(input int ch, input int val);
    bus.cfg_we = 1; bus.cfg_ch = 2'(ch); bus.cfg_preset = W'(val);
    step();
    bus.cfg_we = 0;
  endtask

  task automatic test_reset();
    bus.cfg_we = 0; bus.cfg_ch = 0; bus.cfg_preset = 0; bus.sel_ch = 0;
    model_reset();
    #2;
    nchk++;
    if ({control, done, bus.elapsed, fault} !== '0) begin
      nerr++;
      $display("FAIL reset_state: got ctl=%b done=%b el=%0d f=%b want all 0",
               control, done, bus.elapsed, fault);
    end
    @(posedge clk); #1;
    reset = 0;
    step();
    nchk++;
    if ({control, done, bus.elapsed, fault} !== {m_ctl, m_done, m_el, m_fault}) begin
      nerr++;
      $display("FAIL reset_model: got ctl=%b done=%b el=%0d f=%b want ctl=%b done=%b el=%0d f=%b",
               control, done, bus.elapsed, fault, m_ctl, m_done, m_el, m_fault);
    end
  endtask

  task automatic test_ton();
    idle();
    bus.sel_ch = 0; mode = 8'b00_00_00_10;
    cfg_write(0, 5);
    start = 4'b0001;
    for (int i = 1; i <= 5; i++) begin
      step();
      nchk++;
      if ({control, done} !== {m_ctl, m_done}) begin
        nerr++;
        $display("FAIL ton_model: cyc %0d got ctl=%b done=%b want ctl=%b done=%b",
                 i, control, done, m_ctl, m_done);
      end
    end
    nchk++;
    if ({control[0], done[0]} !== 2'b11) begin
      nerr++;
      $display("FAIL ton_fire: got ctl=%b done=%b want 1 1", control[0], done[0]);
    end
    step();
    nchk++;
    if (bus.elapsed !== 16'd5) begin
      nerr++;
      $display("FAIL ton_elapsed: got %0d want 5", bus.elapsed);
    end
    start = 0;
    step();
    nchk++;
    if (control[0] !== 1'b0) begin
      nerr++;
      $display("FAIL ton_drop: got ctl=%b want 0", control[0]);
    end
    step();
    nchk++;
    if (bus.elapsed !== 16'd0) begin
      nerr++;
      $display("FAIL ton_drop_acc: got %0d want 0", bus.elapsed);
    end
  endtask

  task automatic test_tof();
    idle();
    bus.sel_ch = 1; mode = 8'b00_00_11_00;
    cfg_write(1, 3);
    start = 4'b0010;
    step();
    nchk++;
    if (control[1] !== 1'b1) begin
      nerr++;
      $display("FAIL tof_on: got ctl=%b want 1", control[1]);
    end
    step();
    start = 0;
    for (int i = 1; i <= 3; i++) begin
      step();
      nchk++;
      if ({control[1], done[1]} !== ((i < 3) ? 2'b10 : 2'b01)) begin
        nerr++;
        $display("FAIL tof_hold: cyc %0d got ctl=%b done=%b", i, control[1], done[1]);
      end
    end
    step();
    nchk++;
    if ({control, done, bus.elapsed} !== {m_ctl, m_done, m_el}) begin
      nerr++;
      $display("FAIL tof_model: got ctl=%b done=%b el=%0d want ctl=%b done=%b el=%0d",
               control, done, bus.elapsed, m_ctl, m_done, m_el);
    end
  endtask

  task automatic test_man_change();
    idle();
    bus.sel_ch = 2; mode = 8'b00_01_00_00;
    cfg_write(2, 4);
    start = 4'b0100;
    step();
    nchk++;
    if ({control[2], done[2]} !== 2'b11) begin
      nerr++;
      $display("FAIL man_on: got ctl=%b done=%b want 1 1", control[2], done[2]);
    end
    mode = 8'b00_10_00_00;
    step();
    nchk++;
    if (control[2] !== 1'b0) begin
      nerr++;
      $display("FAIL mode_change: got ctl=%b want 0", control[2]);
    end
    for (int i = 1; i <= 4; i++) begin
      step();
      nchk++;
      if (control[2] !== ((i == 4) ? 1'b1 : 1'b0)) begin
        nerr++;
        $display("FAIL man_to_ton: cyc %0d got ctl=%b", i, control[2]);
      end
    end
  endtask

  task automatic test_estop();
    idle();
    mode = 8'b00_00_11_01;
    step();
    start = 4'b0011;
    step(); step();
    nchk++;
    if (control[1:0] !== 2'b11) begin
      nerr++;
      $display("FAIL estop_pre: got ctl=%b want 11", control[1:0]);
    end
    estop = 1;
    step();
    estop = 0;
    nchk++;
    if ({control, done, fault} !== 9'b0000_0000_1) begin
      nerr++;
      $display("FAIL estop_trip: got ctl=%b done=%b f=%b", control, done, fault);
    end
    step(); step();
    nchk++;
    if ({control, fault} !== 5'b0000_1) begin
      nerr++;
      $display("FAIL estop_interlock: got ctl=%b f=%b want 0000 1", control, fault);
    end
    start = 0;
    step();
    nchk++;
    if (fault !== 1'b0) begin
      nerr++;
      $display("FAIL estop_release: got f=%b want 0", fault);
    end
  endtask

  task automatic test_preset_sat();
    idle();
    mode = 8'b10_00_00_00;
    cfg_write(3, 0);
    start = 4'b1000;
    step();
    nchk++;
    if (control[3] !== 1'b1) begin
      nerr++;
      $display("FAIL preset_zero: got ctl=%b want 1", control[3]);
    end
    idle();
    bus.sel_ch = 0; mode = 8'b00_00_00_10;
    cfg_write(0, MAXV);
    start = 4'b0001;
    repeat (MAXV - 1) step();
    nchk++;
    if ({control[0], bus.elapsed} !== {1'b0, 16'd65533}) begin
      nerr++;
      $display("FAIL sat_before: got ctl=%b el=%0d want 0 65533", control[0], bus.elapsed);
    end
    step();
    nchk++;
    if (control[0] !== 1'b1) begin
      nerr++;
      $display("FAIL sat_fire: got ctl=%b want 1", control[0]);
    end
    step(); step();
    nchk++;
    if (bus.elapsed !== 16'hFFFF || bus.elapsed !== m_el) begin
      nerr++;
      $display("FAIL sat_hold: got el=%0d want 65535", bus.elapsed);
    end
  endtask

  task automatic test_async_reset();
    idle();
    bus.sel_ch = 0; mode = 8'b00_00_00_10;
    cfg_write(0, 10);
    start = 4'b0001;
    repeat (3) step();
    nchk++;
    if ({control, done, bus.elapsed} !== {m_ctl, m_done, m_el} || bus.elapsed == 0) begin
      nerr++;
      $display("FAIL areset_pre: got el=%0d want %0d", bus.elapsed, m_el);
    end
    #2;
    reset = 1;
    model_reset();
    #1;
    nchk++;
    if ({control, done, bus.elapsed, fault} !== '0) begin
      nerr++;
      $display("FAIL areset_clear: got ctl=%b done=%b el=%0d f=%b want 0",
               control, done, bus.elapsed, fault);
    end
    @(posedge clk); #1;
    reset = 0;
    start = 0; mode = 0;
  endtask

  task automatic test_random();
    int bad;
    idle();
    bad = 0;
    for (int c = 0; c < N; c++) mode[2*c +: 2] = 2'($urandom_range(0, 3));
    for (int i = 0; i < 400; i++) begin
      for (int c = 0; c < N; c++) begin
        if ($urandom_range(0, 15) == 0) mode[2*c +: 2] = 2'($urandom_range(0, 3));
        if ($urandom_range(0, 3) == 0) start[c] = ~start[c];
      end
      estop = ($urandom_range(0, 39) == 0);
      bus.cfg_we = ($urandom_range(0, 7) == 0);
      bus.cfg_ch = 2'($urandom_range(0, 3));
      bus.cfg_preset = W'($urandom_range(0, 7));
      bus.sel_ch = 2'($urandom_range(0, 3));
`ifdef RETENTIVE_EN
      clr = ($urandom_range(0, 15) == 0) ? 4'($urandom_range(0, 15)) : '0;
`endif
      step();
      nchk++;
      if ({control, done, bus.elapsed, fault} !== {m_ctl, m_done, m_el, m_fault}) begin
        nerr++;
        bad++;
        if (bad < 10)
          $display("FAIL rand_model: cyc %0d got ctl=%b done=%b el=%0d f=%b want ctl=%b done=%b el=%0d f=%b",
                   i, control, done, bus.elapsed, fault, m_ctl, m_done, m_el, m_fault);
      end
    end
    bus.cfg_we = 0;
  endtask

`ifdef RETENTIVE_EN
  task automatic test_retentive();
    idle();
    bus.sel_ch = 0; mode = 8'b00_00_00_10;
    cfg_write(0, 6);
    start = 4'b0001;
    repeat (4) step();
    start = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      nchk++;
      if ({control[0], bus.elapsed} !== {1'b0, 16'd4}) begin
        nerr++;
        $display("FAIL ret_hold: got ctl=%b el=%0d want 0 4", control[0], bus.elapsed);
      end
    end
    start = 4'b0001;
    step();
    nchk++;
    if (control[0] !== 1'b0) begin
      nerr++;
      $display("FAIL ret_resume: got ctl=%b want 0", control[0]);
    end
    step();
    nchk++;
    if ({control[0], done[0]} !== 2'b11) begin
      nerr++;
      $display("FAIL ret_fire: got ctl=%b done=%b want 1 1", control[0], done[0]);
    end
    start = 0;
    step();
    clr = 4'b0001;
    step();
    clr = 0;
    nchk++;
    if (done[0] !== 1'b0) begin
      nerr++;
      $display("FAIL ret_clr_done: got done=%b want 0", done[0]);
    end
    step();
    nchk++;
    if (bus.elapsed !== 16'd0) begin
      nerr++;
      $display("FAIL ret_clr_acc: got el=%0d want 0", bus.elapsed);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_ton();
    test_tof();
    test_man_change();
    test_estop();
`ifdef RETENTIVE_EN
    test_retentive();
`endif
    test_async_reset();
    test_random();
    test_preset_sat();
    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
